// File: rtl/br_pkg.sv
// Shared constants and divisor type for the fractional baud-rate generator.
// Defaults reproduce the legacy fixed 650-cycle oversample tick.
package br_pkg;

  localparam int BR_INT_W    = 16;
  localparam int BR_FRAC_W   = 4;
  localparam int BR_OSR      = 16;
  localparam int BR_DEF_INT  = 650;
  localparam int BR_DEF_FRAC = 0;
  localparam int BR_MIN_DIV  = 2;

  typedef struct packed {
    logic [BR_INT_W-1:0]  ipart;
    logic [BR_FRAC_W-1:0] fpart;
  } br_div_t;

endpackage

// File: rtl/br_frac_acc.sv
// Fraction accumulator step: adds the fractional divisor to the phase
// accumulator and turns integer part plus carry into a counter reload value.
module br_frac_acc
  import br_pkg::*;
#(
  parameter int INT_W  = BR_INT_W,
  parameter int FRAC_W = BR_FRAC_W
) (
  input  logic [FRAC_W-1:0] acc_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic [INT_W-1:0]  int_i,
  output logic [FRAC_W-1:0] acc_o,
  output logic [INT_W:0]    rl_o
);

  localparam logic [INT_W:0] ONE = (INT_W+1)'(1);

  logic             carry;
  logic [INT_W:0]   period;

  always_comb begin
    {carry, acc_o} = {1'b0, acc_i} + {1'b0, frac_i};
    period = {1'b0, int_i} + {{INT_W{1'b0}}, carry};
    rl_o   = period - ONE;
  end

endmodule

// File: rtl/br_gen_frac.sv
// Fractional baud-rate generator: oversample tick at int+frac/2^FRAC_W cycles
// and a bit tick every OSR oversample ticks, with boundary-safe reload.
module br_gen_frac
  import br_pkg::*;
#(
  parameter int INT_W    = BR_INT_W,
  parameter int FRAC_W   = BR_FRAC_W,
  parameter int OSR      = BR_OSR,
  parameter int DEF_INT  = BR_DEF_INT,
  parameter int DEF_FRAC = BR_DEF_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              sync_clr,
  output logic              tick,
  output logic              bit_tick,
  output logic              div_err
);

  localparam int OSW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OSW-1:0]   OS_LAST = OSW'(OSR-1);
  localparam logic [OSW-1:0]   OS_ONE  = OSW'(1);
  localparam logic [INT_W:0]   CNT_ONE = (INT_W+1)'(1);
  localparam logic [INT_W-1:0] MIN_DIV = INT_W'(BR_MIN_DIV);

  typedef struct packed {
    logic [INT_W-1:0]  ipart;
    logic [FRAC_W-1:0] fpart;
  } div_t;

  div_t              act_q, act_d;
  div_t              pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [INT_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [OSW-1:0]    os_q, os_d;
  logic              err_q, err_d;

  div_t              sel;
  logic              apply_idle;
  logic              reload;
  logic [FRAC_W-1:0] acc_in;
  logic [FRAC_W-1:0] acc_n;
  logic [INT_W:0]    rl;

  assign tick     = en & ~sync_clr & (cnt_q == '0);
  assign bit_tick = tick & (os_q == OS_LAST);
  assign div_err  = err_q;

  // A pending divisor always wins the next reload, whatever triggers it.
  assign sel        = pend_vld_q ? pend_q : act_q;
  assign apply_idle = ~en & pend_vld_q;
  assign reload     = sync_clr | tick | apply_idle;
  assign acc_in     = (sync_clr | apply_idle) ? '0 : acc_q;

  br_frac_acc #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_acc (
    .acc_i  (acc_in),
    .frac_i (sel.fpart),
    .int_i  (sel.ipart),
    .acc_o  (acc_n),
    .rl_o   (rl)
  );

  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    os_d       = os_q;
    err_d      = err_q;

    if (reload) begin
      act_d      = sel;
      pend_vld_d = 1'b0;
      cnt_d      = rl;
      acc_d      = acc_n;
      if (tick) os_d = (os_q == OS_LAST) ? '0 : os_q + OS_ONE;
      else      os_d = '0;
    end else if (en) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    if (div_load) begin
      pend_d.ipart = (div_int < MIN_DIV) ? MIN_DIV : div_int;
      pend_d.fpart = div_frac;
      pend_vld_d   = 1'b1;
      err_d        = (div_int < MIN_DIV);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q      <= '{ipart: INT_W'(DEF_INT), fpart: FRAC_W'(DEF_FRAC)};
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= (INT_W+1)'(DEF_INT-1);
      acc_q      <= '0;
      os_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      os_q       <= os_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/br_gen_frac.md
# br_gen_frac

Parametrised fractional baud-rate generator, successor to the fixed 11-bit integer divider. Produces an oversample tick whose period is a fixed-point divisor (integer + fraction) of `clk`, and a bit tick every `OSR` oversample ticks. Supports glitch-free divisor reload at period boundaries and a synchronous phase clear for receiver start-bit alignment. Sits between the UART register file (divisor source) and the UART TX/RX engines (tick consumers).

## Interface
- `INT_W`, 16, width of integer divisor part
- `FRAC_W`, 4, width of fractional divisor part (LSB weight 2^-FRAC_W)
- `OSR`, 16, oversample ticks per bit tick (>=2)
- `DEF_INT`, 650, integer divisor after reset
- `DEF_FRAC`, 0, fractional divisor after reset
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  generator enable (synchronous to `clk`)
- `div_int`  in  INT_W  requested integer divisor
- `div_frac`  in  FRAC_W  requested fractional divisor
- `div_load`  in  1  one-cycle pulse: capture `div_int`/`div_frac` as pending
- `sync_clr`  in  1  synchronous phase clear
- `tick`  out  1  oversample tick, one-cycle pulse
- `bit_tick`  out  1  bit-rate tick, one-cycle pulse coincident with a `tick`
- `div_err`  out  1  sticky: last loaded `div_int` < 2 (clamped)

## Operation
- State: active divisor (`act_int`, `act_frac`), pending divisor + `pend_vld`, down-counter `cnt` (INT_W+1 bits), accumulator `acc` (FRAC_W bits), `os_cnt` (0..OSR-1).
- Period computation at every counter reload: `{c, acc_n} = acc + act_frac`; period P = `act_int + c`; `cnt <= P-1`; `acc <= acc_n`.
- `tick = en & (cnt == 0)`; combinational decode of flops and `en`. On tick, counter reloads per above.
- `os_cnt` advances on each tick, wraps OSR-1 -> 0; `bit_tick = tick & (os_cnt == OSR-1)`.
- `en=0`: `cnt`, `acc`, `os_cnt` hold; no ticks. Pending divisor, if any, is applied immediately (counter reloaded with acc forced to 0, os_cnt=0).
- `div_load` with `en=1`: stored as pending; applied at the reload following the next tick; the current period is never shortened or stretched. A second `div_load` before application overwrites pending.
- `div_int` < 2 on load: clamped to 2, `div_err` set; cleared by the next load with `div_int` >= 2.
- `sync_clr`: `acc<=0`, `os_cnt<=0`, counter reloaded from active (or pending, if `pend_vld`, which is then consumed); no tick in that cycle. Priority: `rst` > `sync_clr` > tick reload > hold.
- Average tick period = `div_int + div_frac/2^FRAC_W` cycles; per-period jitter <= 1 cycle.

## Timing
- Reset: `act_int=DEF_INT`, `act_frac=DEF_FRAC`, `cnt=DEF_INT-1`, `acc=0`, `os_cnt=0`, `pend_vld=0`, `div_err=0`; `tick=0`, `bit_tick=0`.
- From reset/clear with fraction 0: first `tick` in the `div_int`-th cycle with `en=1`, then every `div_int` cycles.
- `div_load` -> pending: 1 cycle; takes effect on the period starting the cycle after the next tick.
- `sync_clr` high in cycle k: cycle k+1 has `cnt=P-1`; next tick in cycle k+P.
- Reset mid-period: all state returns to reset values immediately (async), no partial tick.

## Structure
- Package `br_pkg`: default divisor constants, min divisor constant (2), typedef for the fixed-point divisor struct `{int, frac}`.
- One sub-module `br_frac_acc`: accumulator + carry-out and period computation; top holds counters, reload control, pending register.

## Test plan
- Legacy: `div_int=650`, frac 0, `en=1` -> ticks every 650 cycles, `bit_tick` every 10400 cycles.
- Fraction: `div_int=3`, `div_frac=8` -> tick periods 3,4,3,4…; 16 ticks in exactly 56 cycles.
- Reload mid-period: running at 10, `div_load` with 5 at count 4 -> current period stays 10, following periods 5.
- `sync_clr` at random phase, `OSR=16` -> next tick exactly P cycles later, `bit_tick` on 16th tick thereafter.
- `div_int=1` load -> `div_err=1`, period 2; then load 8 -> `div_err=0`, period 8.
- `rst` asserted mid-period and `en` toggled low/high -> counter frozen while low, no tick lost or duplicated; outputs 0 during reset.
